// File: rtl/pcie_us_msix_irq_sched.sv
// MSI-X interrupt scheduler for the UltraScale PCIe cfg_interrupt_msix_* interface.
// Holds the vector table and PBA, round-robin arbitrates pending vectors, one message in flight.
module pcie_us_msix_irq_sched #(
  parameter int unsigned IRQ_COUNT      = 32,
  parameter int unsigned IDX_W          = $clog2(IRQ_COUNT),
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IRQ_COUNT-1:0] irq_req,
  input  logic                 tbl_wr_en,
  input  logic [IDX_W-1:0]     tbl_wr_index,
  input  logic [63:0]          tbl_wr_addr,
  input  logic [31:0]          tbl_wr_data,
  input  logic                 tbl_wr_mask,
  output logic [IRQ_COUNT-1:0] pba,
  input  logic [1:0]           cfg_interrupt_msix_enable,
  input  logic [1:0]           cfg_interrupt_msix_mask,
  output logic [63:0]          cfg_interrupt_msix_address,
  output logic [31:0]          cfg_interrupt_msix_data,
  output logic                 cfg_interrupt_msix_int,
  input  logic                 cfg_interrupt_msix_sent,
  input  logic                 cfg_interrupt_msix_fail,
  output logic                 busy,
  output logic                 timeout
);

  localparam int unsigned TMR_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [63:0]          addr_tbl [IRQ_COUNT];
  logic [31:0]          data_tbl [IRQ_COUNT];
  logic [IRQ_COUNT-1:0] mask_tbl;
  logic [IRQ_COUNT-1:0] pending;
  logic [IRQ_COUNT-1:0] eligible;
  logic [IRQ_COUNT-1:0] clr_vec;
  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     cur_idx;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_valid;
  int unsigned          cand;
  logic [TMR_W-1:0]     timer;
  logic                 grant_c;
  logic                 done_c;
  logic                 clear_c;
  logic                 timeout_c;
  logic                 unused_bits;

  // Only function 0 is served.
  assign unused_bits = cfg_interrupt_msix_enable[1] ^ cfg_interrupt_msix_mask[1];

  assign pba      = pending;
  assign eligible = pending & ~mask_tbl
                  & {IRQ_COUNT{cfg_interrupt_msix_enable[0] & ~cfg_interrupt_msix_mask[0]}};

  // Vector table; out-of-range indices match no entry and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < IRQ_COUNT; i++) begin
        addr_tbl[i] <= '0;
        data_tbl[i] <= '0;
      end
      mask_tbl <= '1;
    end else begin
      for (int unsigned i = 0; i < IRQ_COUNT; i++) begin
        if (tbl_wr_en && (tbl_wr_index == IDX_W'(i))) begin
          addr_tbl[i] <= tbl_wr_addr;
          data_tbl[i] <= tbl_wr_data;
          mask_tbl[i] <= tbl_wr_mask;
        end
      end
    end
  end

  // Round robin: first eligible vector after last_grant, wrapping.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= IRQ_COUNT; k++) begin
      cand = 32'(last_grant) + k;
      if (cand >= IRQ_COUNT) cand = cand - IRQ_COUNT;
      if (!sel_valid && eligible[IDX_W'(cand)]) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_c    = 1'b0;
    done_c     = 1'b0;
    clear_c    = 1'b0;
    timeout_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (sel_valid) begin
          grant_c    = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        if (cfg_interrupt_msix_fail) begin
          done_c     = 1'b1;
          state_next = S_IDLE;
        end else if (cfg_interrupt_msix_sent) begin
          done_c     = 1'b1;
          clear_c    = 1'b1;
          state_next = S_IDLE;
        end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          done_c     = 1'b1;
          timeout_c  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    clr_vec = '0;
    if (clear_c) clr_vec[cur_idx] = 1'b1;
  end

  // A new request always wins over the clear of the same vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~clr_vec) | irq_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_idx                    <= '0;
      last_grant                 <= IDX_W'(IRQ_COUNT - 1);
      cfg_interrupt_msix_address <= '0;
      cfg_interrupt_msix_data    <= '0;
      cfg_interrupt_msix_int     <= 1'b0;
      timeout                    <= 1'b0;
      busy                       <= 1'b0;
      timer                      <= '0;
    end else begin
      cfg_interrupt_msix_int <= grant_c;
      timeout                <= timeout_c;
      busy                   <= (state_next != S_IDLE);
      if (grant_c) begin
        cur_idx                    <= sel_idx;
        cfg_interrupt_msix_address <= addr_tbl[sel_idx];
        cfg_interrupt_msix_data    <= data_tbl[sel_idx];
      end
      if (done_c) last_grant <= cur_idx;
      if (state == S_ISSUE)     timer <= '0;
      else if (state == S_WAIT) timer <= timer + TMR_W'(1);
    end
  end

endmodule

// File: tb/tb_pcie_us_msix_irq_sched.sv
// Directed bench for pcie_us_msix_irq_sched: table-driven single-vector issue plus
// hand sequences for round robin, masking, fail/retry, timeout, race and reset.
module tb_pcie_us_msix_irq_sched;

  localparam int unsigned N   = 20;
  localparam int unsigned IW  = 5;
  localparam int unsigned TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  irq_req;
  logic          tbl_wr_en;
  logic [IW-1:0] tbl_wr_index;
  logic [63:0]   tbl_wr_addr;
  logic [31:0]   tbl_wr_data;
  logic          tbl_wr_mask;
  logic [N-1:0]  pba;
  logic [1:0]    msix_enable;
  logic [1:0]    msix_mask;
  logic [63:0]   msix_address;
  logic [31:0]   msix_data;
  logic          msix_int;
  logic          msix_sent;
  logic          msix_fail;
  logic          busy;
  logic          timeout;

  int checks   = 0;
  int failures = 0;

  pcie_us_msix_irq_sched #(
    .IRQ_COUNT(N),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .irq_req(irq_req),
    .tbl_wr_en(tbl_wr_en),
    .tbl_wr_index(tbl_wr_index),
    .tbl_wr_addr(tbl_wr_addr),
    .tbl_wr_data(tbl_wr_data),
    .tbl_wr_mask(tbl_wr_mask),
    .pba(pba),
    .cfg_interrupt_msix_enable(msix_enable),
    .cfg_interrupt_msix_mask(msix_mask),
    .cfg_interrupt_msix_address(msix_address),
    .cfg_interrupt_msix_data(msix_data),
    .cfg_interrupt_msix_int(msix_int),
    .cfg_interrupt_msix_sent(msix_sent),
    .cfg_interrupt_msix_fail(msix_fail),
    .busy(busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned vec;
    logic [63:0] addr;
    logic [31:0] data;
    logic        mask;
    logic        exp_int;
    logic [63:0] exp_addr;
    logic [31:0] exp_data;
  } vec_rec_t;

  vec_rec_t tbl [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_strobes();
    irq_req   = '0;
    tbl_wr_en = 1'b0;
    msix_sent = 1'b0;
    msix_fail = 1'b0;
  endtask

  task automatic wr(input int unsigned v, input logic [63:0] a, input logic [31:0] d, input logic m);
    tbl_wr_en    = 1'b1;
    tbl_wr_index = IW'(v);
    tbl_wr_addr  = a;
    tbl_wr_data  = d;
    tbl_wr_mask  = m;
  endtask

  logic [31:0] rr_data [3];
  int unsigned rr_vec  [3];

  initial begin
    tbl[0] = '{3,  64'h0000_0000_FEE0_0000, 32'h0000_0041, 1'b0, 1'b1, 64'h0000_0000_FEE0_0000, 32'h0000_0041};
    tbl[1] = '{0,  64'h1234_5678_9ABC_DEF3, 32'hDEAD_BEEF, 1'b0, 1'b1, 64'h1234_5678_9ABC_DEF3, 32'hDEAD_BEEF};
    tbl[2] = '{19, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFF, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFF};
    tbl[3] = '{2,  64'h0000_0000_FEE0_1002, 32'h0000_0022, 1'b1, 1'b0, 64'h0000_0000_FEE0_1002, 32'h0000_0022};
    tbl[4] = '{7,  64'h0000_0000_FEE0_7000, 32'h0000_0777, 1'b0, 1'b1, 64'h0000_0000_FEE0_7000, 32'h0000_0777};
    rr_vec[0] = 0; rr_data[0] = 32'hDEAD_BEEF;
    rr_vec[1] = 1; rr_data[1] = 32'h0000_0101;
    rr_vec[2] = 5; rr_data[2] = 32'h0000_0505;

    rst_n = 1'b0; clr_strobes();
    tbl_wr_index = '0; tbl_wr_addr = '0; tbl_wr_data = '0; tbl_wr_mask = 1'b0;
    msix_enable = 2'b00; msix_mask = 2'b00;
    step(); step();
    check("rst_pba", 64'(pba), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_int", 64'(msix_int), 64'h0);
    check("rst_addr", msix_address, 64'h0);
    check("rst_data", 64'(msix_data), 64'h0);
    check("rst_timeout", 64'(timeout), 64'h0);
    rst_n = 1'b1;
    msix_enable = 2'b01;
    step();

    // Table-driven single-vector issue; last row leaves last_grant = 7.
    for (int r = 0; r < 5; r++) begin
      wr(tbl[r].vec, tbl[r].addr, tbl[r].data, tbl[r].mask);
      irq_req[tbl[r].vec] = 1'b1;
      step(); clr_strobes();
      check($sformatf("row%0d_pba_set", r), 64'(pba[tbl[r].vec]), 64'h1);
      check($sformatf("row%0d_int_t1", r), 64'(msix_int), 64'h0);
      step();
      check($sformatf("row%0d_int_t2", r), 64'(msix_int), 64'(tbl[r].exp_int));
      if (!tbl[r].exp_int) begin
        step(); step();
        check($sformatf("row%0d_masked_int", r), 64'(msix_int), 64'h0);
        check($sformatf("row%0d_masked_busy", r), 64'(busy), 64'h0);
        check($sformatf("row%0d_masked_pba", r), 64'(pba[tbl[r].vec]), 64'h1);
        wr(tbl[r].vec, tbl[r].addr, tbl[r].data, 1'b0);
        step(); clr_strobes();
        check($sformatf("row%0d_unmask_t1", r), 64'(msix_int), 64'h0);
        step();
        check($sformatf("row%0d_unmask_t2", r), 64'(msix_int), 64'h1);
      end
      check($sformatf("row%0d_addr", r), msix_address, tbl[r].exp_addr);
      check($sformatf("row%0d_data", r), 64'(msix_data), 64'(tbl[r].exp_data));
      check($sformatf("row%0d_busy", r), 64'(busy), 64'h1);
      step(); msix_sent = 1'b1;
      check($sformatf("row%0d_wait_int", r), 64'(msix_int), 64'h0);
      check($sformatf("row%0d_wait_addr", r), msix_address, tbl[r].exp_addr);
      step(); clr_strobes();
      check($sformatf("row%0d_pba_clr", r), 64'(pba), 64'h0);
      check($sformatf("row%0d_idle", r), 64'(busy), 64'h0);
    end

    // Round robin over 0, 1, 5 with sent one cycle after each int.
    wr(1, 64'h0000_0000_FEE0_0004, 32'h0000_0101, 1'b0); step();
    wr(5, 64'h0000_0000_FEE0_0014, 32'h0000_0505, 1'b0); step(); clr_strobes();
    irq_req[0] = 1'b1; irq_req[1] = 1'b1; irq_req[5] = 1'b1;
    step(); clr_strobes();
    step();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rr%0d_int", rr_vec[k]), 64'(msix_int), 64'h1);
      check($sformatf("rr%0d_data", rr_vec[k]), 64'(msix_data), 64'(rr_data[k]));
      step(); msix_sent = 1'b1;
      step(); clr_strobes();
      check($sformatf("rr%0d_gap", rr_vec[k]), 64'(msix_int), 64'h0);
      step();
    end
    check("rr_pba_empty", 64'(pba), 64'h0);
    check("rr_idle", 64'(busy), 64'h0);

    // Global function mask holds vector 2 pending.
    msix_mask = 2'b01;
    irq_req[2] = 1'b1;
    step(); clr_strobes();
    step(); step();
    check("gmask_int", 64'(msix_int), 64'h0);
    check("gmask_busy", 64'(busy), 64'h0);
    check("gmask_pba", 64'(pba[2]), 64'h1);
    msix_mask = 2'b00;
    step();
    check("gunmask_int", 64'(msix_int), 64'h1);
    check("gunmask_data", 64'(msix_data), 64'h22);
    step(); msix_sent = 1'b1;
    step(); clr_strobes();
    check("gmask_pba_clr", 64'(pba), 64'h0);

    // Enable low behaves like a global mask.
    msix_enable = 2'b00;
    irq_req[2] = 1'b1;
    step(); clr_strobes();
    step(); step();
    check("en_off_int", 64'(msix_int), 64'h0);
    check("en_off_pba", 64'(pba[2]), 64'h1);
    msix_enable = 2'b01;
    step();
    check("en_on_int", 64'(msix_int), 64'h1);
    step(); msix_sent = 1'b1;
    step(); clr_strobes();

    // Fail keeps pending and moves on; sent+fail counts as fail.
    irq_req[0] = 1'b1; irq_req[1] = 1'b1;
    step(); clr_strobes();
    step();
    check("fail_v0_int", 64'(msix_int), 64'h1);
    check("fail_v0_data", 64'(msix_data), 64'hDEAD_BEEF);
    step(); msix_fail = 1'b1;
    step(); clr_strobes();
    check("fail_pba_kept", 64'(pba), 64'h3);
    check("fail_gap", 64'(msix_int), 64'h0);
    step();
    check("fail_v1_int", 64'(msix_int), 64'h1);
    check("fail_v1_data", 64'(msix_data), 64'h101);
    step(); msix_sent = 1'b1;
    step(); clr_strobes();
    check("fail_v1_cleared", 64'(pba), 64'h1);
    step();
    check("retry_v0_int", 64'(msix_int), 64'h1);
    check("retry_v0_data", 64'(msix_data), 64'hDEAD_BEEF);
    step(); msix_sent = 1'b1; msix_fail = 1'b1;
    step(); clr_strobes();
    check("sentfail_pba", 64'(pba), 64'h1);
    step();
    check("retry2_v0_int", 64'(msix_int), 64'h1);
    step(); msix_sent = 1'b1;
    step(); clr_strobes();
    check("retry_pba_clr", 64'(pba), 64'h0);

    // Timeout: 16 silent WAIT cycles, pulse as the FSM returns to IDLE, then reissue.
    irq_req[3] = 1'b1;
    step(); clr_strobes();
    step();
    check("tmo_int", 64'(msix_int), 64'h1);
    for (int j = 1; j <= 16; j++) step();
    check("tmo_not_yet", 64'(timeout), 64'h0);
    check("tmo_still_busy", 64'(busy), 64'h1);
    step();
    check("tmo_pulse", 64'(timeout), 64'h1);
    check("tmo_pba", 64'(pba[3]), 64'h1);
    check("tmo_idle", 64'(busy), 64'h0);
    step();
    check("tmo_pulse_end", 64'(timeout), 64'h0);
    check("tmo_reissue", 64'(msix_int), 64'h1);
    check("tmo_reissue_data", 64'(msix_data), 64'h41);
    step(); msix_sent = 1'b1;
    step(); clr_strobes();
    check("tmo_pba_clr", 64'(pba), 64'h0);

    // Same-cycle irq_req and sent keeps the bit; mid-flight rewrite does not disturb outputs.
    irq_req[5] = 1'b1;
    step(); clr_strobes();
    step();
    check("race_int", 64'(msix_int), 64'h1);
    step(); msix_sent = 1'b1; irq_req[5] = 1'b1;
    step(); clr_strobes();
    check("race_pba", 64'(pba[5]), 64'h1);
    step();
    check("race_reissue", 64'(msix_int), 64'h1);
    check("race_reissue_data", 64'(msix_data), 64'h505);
    step();
    wr(5, 64'h0000_0000_DEAD_0000, 32'h0000_0999, 1'b1);
    step(); clr_strobes();
    check("midflight_data", 64'(msix_data), 64'h505);
    check("midflight_addr", msix_address, 64'h0000_0000_FEE0_0014);
    check("midflight_busy", 64'(busy), 64'h1);
    msix_sent = 1'b1;
    step(); clr_strobes();
    check("midflight_pba_clr", 64'(pba), 64'h0);
    check("midflight_idle", 64'(busy), 64'h0);

    // Asynchronous reset in WAIT drops everything at once.
    irq_req[1] = 1'b1; irq_req[3] = 1'b1;
    step(); clr_strobes();
    step();
    check("rstw_int", 64'(msix_int), 64'h1);
    check("rstw_data", 64'(msix_data), 64'h101);
    step();
    rst_n = 1'b0;
    #1;
    check("rstw_pba", 64'(pba), 64'h0);
    check("rstw_busy", 64'(busy), 64'h0);
    check("rstw_int0", 64'(msix_int), 64'h0);
    check("rstw_addr", msix_address, 64'h0);
    step();
    rst_n = 1'b1;
    step();
    irq_req[3] = 1'b1;
    step(); clr_strobes();
    step(); step();
    check("post_rst_masked_int", 64'(msix_int), 64'h0);
    check("post_rst_pba", 64'(pba[3]), 64'h1);
    check("post_rst_busy", 64'(busy), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
